msk_rnd_source: RTL and testbench

//  Producer side of the gadget "rnd" bus: supplies fresh pseudo-random bits each cycle to masked gadgets.

---
 rtl/msk_rnd_source_pkg.sv | 17 +
 rtl/msk_rnd_source_lane.sv | 50 +++++
 rtl/msk_rnd_source.sv | 134 +++++++++++++
 tb/tb_msk_rnd_source.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_rnd_source_pkg.sv
// Shared constants and FSM state type for the masked-gadget randomness source.
package msk_rnd_source_pkg;

    localparam int unsigned XS_SHIFT_A          = 11;
    localparam int unsigned XS_SHIFT_B          = 19;
    localparam int unsigned XS_SHIFT_C          = 8;
    localparam int unsigned SEED_WORDS_PER_LANE = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_PRIME     = 3'd2,
        ST_RUN       = 3'd3,
        ST_EXHAUSTED = 3'd4
    } state_t;

endpackage

// File: rtl/msk_rnd_source_lane.sv
// One xorshift128 lane: seed-word loading, all-zero rescue and single-step update.
// The w output is the w the lane will hold after its next step, so the top can
// register it into rnd_out on the same edge the lane advances.
module msk_xorshift128_lane
    import msk_rnd_source_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic [1:0]  load_idx,
    input  logic [31:0] load_word,
    input  logic        fix_zero,
    input  logic        step_en,
    output logic [31:0] w
);

    logic [31:0] x_q, y_q, z_q, w_q;
    logic [31:0] x_eff;
    logic [31:0] t;

    // Next-w computation; an all-zero state is treated as x=1 while fix_zero is high.
    always_comb begin
        x_eff = (fix_zero && ({x_q, y_q, z_q, w_q} == '0)) ? 32'h1 : x_q;
        t     = x_eff ^ (x_eff << XS_SHIFT_A);
        w     = w_q ^ (w_q >> XS_SHIFT_B) ^ t ^ (t >> XS_SHIFT_C);
    end

    // Lane state: seed-word load has priority over stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
            w_q <= '0;
        end else if (load_en) begin
            case (load_idx)
                2'd0:    x_q <= load_word;
                2'd1:    y_q <= load_word;
                2'd2:    z_q <= load_word;
                default: w_q <= load_word;
            endcase
        end else if (step_en) begin
            x_q <= y_q;
            y_q <= z_q;
            z_q <= w_q;
            w_q <= w;
        end
    end

endmodule

// File: rtl/msk_rnd_source.sv
// Randomness producer for masked gadgets: xorshift128 lanes seeded over a
// valid/ready word port, output on a valid/ready bus with optional reseed limit.
module msk_rnd_source
    import msk_rnd_source_pkg::*;
#(
    parameter int unsigned W             = 32,
    parameter int unsigned RESEED_PERIOD = 0,
    parameter int unsigned CNT_W         = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  seed_in,
    input  logic         seed_valid,
    output logic         seed_ready,
    output logic [W-1:0] rnd_out,
    output logic         rnd_valid,
    input  logic         rnd_ready,
    output logic         seeded,
    output logic         reseed_req
);

    localparam int unsigned LANES     = (W + 31) / 32;
    localparam int unsigned NWORDS    = SEED_WORDS_PER_LANE * LANES;
    localparam int unsigned WCNT_W    = $clog2(NWORDS);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(NWORDS - 1);
    localparam logic [CNT_W-1:0]  OCNT_LAST = CNT_W'((RESEED_PERIOD == 0) ? 0 : RESEED_PERIOD - 1);

    state_t              state;
    logic [WCNT_W-1:0]   wcnt;
    logic [CNT_W-1:0]    ocnt;
    logic                seed_hs;
    logic                rnd_acc;
    logic                last_word;
    logic                step_en;
    logic                fix_zero;
    logic [1:0]          load_idx;
    logic [LANES*32-1:0] all_w;
    logic                spare_unused;

    // Handshake decode and lane control; the final word of a seeding period does not step the lanes.
    always_comb begin
        seed_hs      = seed_valid & seed_ready;
        rnd_acc      = rnd_valid & rnd_ready;
        last_word    = rnd_acc && (RESEED_PERIOD != 0) && (ocnt == OCNT_LAST);
        fix_zero     = (state == ST_PRIME);
        step_en      = (state == ST_PRIME) || (rnd_acc && !last_word);
        load_idx     = 2'(wcnt % SEED_WORDS_PER_LANE);
        // lane bits above W are dropped from rnd_out
        spare_unused = ^all_w;
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic lane_load;

        // Seed word goes to the lane owning the current word index.
        always_comb lane_load = seed_hs && ((32'(wcnt) / SEED_WORDS_PER_LANE) == k);

        msk_xorshift128_lane u_lane (
            .clk      (clk),
            .rst      (rst),
            .load_en  (lane_load),
            .load_idx (load_idx),
            .load_word(seed_in),
            .fix_zero (fix_zero),
            .step_en  (step_en),
            .w        (all_w[32*k +: 32])
        );
    end

    // Sequencing FSM with registered handshake/status outputs and the rnd_out register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wcnt       <= '0;
            ocnt       <= '0;
            seed_ready <= 1'b0;
            rnd_valid  <= 1'b0;
            rnd_out    <= '0;
            seeded     <= 1'b0;
            reseed_req <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_EXHAUSTED: begin
                    seed_ready <= 1'b1;
                    if (seed_hs) begin
                        state      <= ST_LOAD;
                        wcnt       <= WCNT_W'(1);
                        reseed_req <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (seed_hs) begin
                        if (wcnt == WCNT_LAST) begin
                            state      <= ST_PRIME;
                            wcnt       <= '0;
                            seed_ready <= 1'b0;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                ST_PRIME: begin
                    state     <= ST_RUN;
                    ocnt      <= '0;
                    rnd_valid <= 1'b1;
                    seeded    <= 1'b1;
                    rnd_out   <= all_w[W-1:0];
                end
                ST_RUN: begin
                    if (rnd_acc) begin
                        if (last_word) begin
                            state      <= ST_EXHAUSTED;
                            rnd_valid  <= 1'b0;
                            seeded     <= 1'b0;
                            reseed_req <= 1'b1;
                            seed_ready <= 1'b1;
                        end else begin
                            rnd_out <= all_w[W-1:0];
                            ocnt    <= ocnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    seed_ready <= 1'b0;
                    rnd_valid  <= 1'b0;
                    seeded     <= 1'b0;
                    reseed_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msk_rnd_source.sv
// Bench for msk_rnd_source: three instances (W=32 unlimited, W=32 period 3,
// W=40 two lanes) driven one after another against an xorshift128 reference model.
module tb_msk_rnd_source;

    logic        clk;
    logic        rst;
    logic [31:0] seed_in    [3];
    logic        seed_valid [3];
    logic        seed_ready [3];
    logic        rnd_valid  [3];
    logic        rnd_ready  [3];
    logic        seeded     [3];
    logic        reseed_req [3];
    logic [31:0] rnd_a;
    logic [31:0] rnd_b;
    logic [39:0] rnd_c;

    int n_assert = 0;
    int n_fail   = 0;

    logic [39:0]  exp_q[$];
    logic [127:0] ms [2];
    logic [31:0]  std8  [8];
    logic [31:0]  zero8 [8];
    logic [31:0]  dual8 [8];

    msk_rnd_source #(.W(32), .RESEED_PERIOD(0), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .seed_in(seed_in[0]), .seed_valid(seed_valid[0]),
        .seed_ready(seed_ready[0]), .rnd_out(rnd_a), .rnd_valid(rnd_valid[0]),
        .rnd_ready(rnd_ready[0]), .seeded(seeded[0]), .reseed_req(reseed_req[0])
    );

    msk_rnd_source #(.W(32), .RESEED_PERIOD(3), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .seed_in(seed_in[1]), .seed_valid(seed_valid[1]),
        .seed_ready(seed_ready[1]), .rnd_out(rnd_b), .rnd_valid(rnd_valid[1]),
        .rnd_ready(rnd_ready[1]), .seeded(seeded[1]), .reseed_req(reseed_req[1])
    );

    msk_rnd_source #(.W(40), .RESEED_PERIOD(0), .CNT_W(32)) dut_c (
        .clk(clk), .rst(rst), .seed_in(seed_in[2]), .seed_valid(seed_valid[2]),
        .seed_ready(seed_ready[2]), .rnd_out(rnd_c), .rnd_valid(rnd_valid[2]),
        .rnd_ready(rnd_ready[2]), .seeded(seeded[2]), .reseed_req(reseed_req[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [127:0] xs_step(input logic [127:0] s);
        logic [31:0] x, y, z, w, t;
        {x, y, z, w} = s;
        t = x ^ (x << 11);
        return {y, z, w, w ^ (w >> 19) ^ t ^ (t >> 8)};
    endfunction

    function automatic logic [39:0] rnd_of(input int d);
        case (d)
            0:       return {8'h00, rnd_a};
            1:       return {8'h00, rnd_b};
            default: return rnd_c;
        endcase
    endfunction

    function automatic int lanes_of(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_push(input int lanes);
        if (lanes == 2) exp_q.push_back({ms[1][7:0], ms[0][31:0]});
        else            exp_q.push_back({8'h00, ms[0][31:0]});
    endtask

    // Load the model, apply the all-zero rescue, prime once, queue the first word.
    task automatic model_seed(input logic [31:0] words [8], input int lanes);
        exp_q.delete();
        for (int l = 0; l < lanes; l++) begin
            ms[l] = {words[4*l], words[4*l+1], words[4*l+2], words[4*l+3]};
            if (ms[l] == '0) ms[l][127:96] = 32'h1;
            ms[l] = xs_step(ms[l]);
        end
        model_push(lanes);
    endtask

    task automatic model_advance(input int lanes);
        for (int l = 0; l < lanes; l++) ms[l] = xs_step(ms[l]);
        model_push(lanes);
    endtask

    task automatic send_seed(input int d, input logic [31:0] words [8], input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            seed_valid[d] = 1'b1;
            seed_in[d]    = words[i];
            while (seed_ready[d] !== 1'b1 && guard < 20) begin
                tick();
                guard++;
            end
            chk("seed_ready_wait", 40'(seed_ready[d]), 40'd1);
            tick();
            seed_valid[d] = 1'b0;
        end
    endtask

    task automatic do_reset(input int d);
        rst = 1'b1;
        tick();
        chk("rst_seed_ready", 40'(seed_ready[d]), 40'd0);
        chk("rst_rnd_valid",  40'(rnd_valid[d]),  40'd0);
        chk("rst_rnd_out",    rnd_of(d),          40'd0);
        chk("rst_seeded",     40'(seeded[d]),     40'd0);
        chk("rst_reseed_req", 40'(reseed_req[d]), 40'd0);
        rst = 1'b0;
    endtask

    // Consume n words, optionally with random stalls and seed-port noise.
    task automatic drain(input int d, input int n, input bit stall, input bit noise);
        int   got;
        int   cyc;
        logic r;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 400) begin
            r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            rnd_ready[d] = r;
            if (noise) begin
                seed_valid[d] = 1'b1;
                seed_in[d]    = $urandom;
            end
            chk("run_rnd_valid",  40'(rnd_valid[d]),  40'd1);
            chk("run_seeded",     40'(seeded[d]),     40'd1);
            chk("run_seed_ready", 40'(seed_ready[d]), 40'd0);
            if (exp_q.size() == 0) chk("sb_empty", 40'd0, 40'd1);
            else                   chk("rnd_out", rnd_of(d), exp_q[0]);
            tick();
            if (r) begin
                void'(exp_q.pop_front());
                model_advance(lanes_of(d));
                got++;
            end
            cyc++;
        end
        chk("drain_count", 40'(got), 40'(n));
        rnd_ready[d]  = 1'b0;
        seed_valid[d] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            seed_in[d]    = '0;
            seed_valid[d] = 1'b0;
            rnd_ready[d]  = 1'b0;
        end
        std8  = '{32'd123456789, 32'd362436069, 32'd521288629, 32'd88675123, 0, 0, 0, 0};
        zero8 = '{0, 0, 0, 0, 0, 0, 0, 0};
        dual8 = '{32'd123456789, 32'd362436069, 32'd521288629, 32'd88675123,
                  32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0BADF00D};
        tick();
        tick();

        // Known-answer sequence, back-to-back, latency through PRIME.
        do_reset(0);
        rnd_ready[0] = 1'b1;
        send_seed(0, std8, 4);
        chk("t1_prime_valid", 40'(rnd_valid[0]), 40'd0);
        model_seed(std8, 1);
        tick();
        chk("t1_word0", rnd_of(0), 40'h00DCA345EA);
        drain(0, 1, 1'b0, 1'b0);
        chk("t1_word1", rnd_of(0), 40'h001B5116E6);
        drain(0, 6, 1'b0, 1'b0);

        // Stall right after rnd_valid rises: word held, then resumes without skip.
        do_reset(0);
        rnd_ready[0] = 1'b0;
        send_seed(0, std8, 4);
        model_seed(std8, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t2_stall_valid", 40'(rnd_valid[0]), 40'd1);
            chk("t2_stall_word",  rnd_of(0), 40'h00DCA345EA);
            tick();
        end
        drain(0, 1, 1'b0, 1'b0);
        chk("t2_after_stall", rnd_of(0), 40'h001B5116E6);
        drain(0, 10, 1'b1, 1'b0);

        // Reset during a RUN stall: no old word may surface afterwards.
        do_reset(0);
        rnd_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_post_rst_valid", 40'(rnd_valid[0]), 40'd0);
            tick();
        end

        // Partial seeding holds; reset mid-LOAD (with a word offered) discards it.
        send_seed(0, std8, 2);
        for (int i = 0; i < 3; i++) begin
            chk("t5_partial_valid", 40'(rnd_valid[0]), 40'd0);
            tick();
        end
        seed_valid[0] = 1'b1;
        seed_in[0]    = std8[2];
        do_reset(0);
        seed_valid[0] = 1'b0;
        send_seed(0, std8, 4);
        chk("t5_prime_valid", 40'(rnd_valid[0]), 40'd0);
        model_seed(std8, 1);
        tick();
        chk("t5_restart_word0", rnd_of(0), 40'h00DCA345EA);
        drain(0, 3, 1'b0, 1'b0);

        // All-zero seed is rescued.
        do_reset(0);
        send_seed(0, zero8, 4);
        model_seed(zero8, 1);
        tick();
        chk("t3_nonzero", 40'(rnd_of(0) != 40'd0), 40'd1);
        drain(0, 4, 1'b0, 1'b0);

        // Reseed limit of 3 words, then reseeding reproduces the sequence.
        do_reset(1);
        send_seed(1, std8, 4);
        model_seed(std8, 1);
        tick();
        drain(1, 3, 1'b0, 1'b0);
        rnd_ready[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("t4_exh_valid",      40'(rnd_valid[1]),  40'd0);
            chk("t4_exh_reseed_req", 40'(reseed_req[1]), 40'd1);
            chk("t4_exh_seed_ready", 40'(seed_ready[1]), 40'd1);
            chk("t4_exh_seeded",     40'(seeded[1]),     40'd0);
            tick();
        end
        rnd_ready[1] = 1'b0;
        send_seed(1, std8, 4);
        chk("t4_reseed_req_clr", 40'(reseed_req[1]), 40'd0);
        chk("t4_prime_valid",    40'(rnd_valid[1]),  40'd0);
        model_seed(std8, 1);
        tick();
        chk("t4_reseed_word0", rnd_of(1), 40'h00DCA345EA);
        drain(1, 3, 1'b0, 1'b0);
        chk("t4_exh_again", 40'(reseed_req[1]), 40'd1);

        // Two lanes, truncated to 40 bits, seed port noise during RUN.
        do_reset(2);
        send_seed(2, dual8, 8);
        chk("t6_prime_valid", 40'(rnd_valid[2]), 40'd0);
        model_seed(dual8, 2);
        tick();
        drain(2, 12, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
